// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, counter encodings and counter update function
package cpu_pkg;

    // instr[6:2] encodings of the control-transfer instructions
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    // 2-bit saturating direction counter; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Next counter value for an entry being written.
    //   hit     : the existing entry is valid and carries the same tag
    //   is_jump : JAL/JALR, always strongly taken
    //   taken   : resolved branch direction
    function automatic ctr_t ctr_next(input logic hit, input logic is_jump,
                                      input logic taken, input ctr_t ctr);
        ctr_t nxt;
        nxt = WNT;
        if (is_jump) begin
            nxt = ST;
        end else if (!hit) begin
            // fresh entry starts weak in the observed direction
            nxt = taken ? WT : WNT;
        end else begin
            case (ctr)
                SNT:     nxt = taken ? WNT : SNT;
                WNT:     nxt = taken ? WT  : SNT;
                WT:      nxt = taken ? ST  : WNT;
                ST:      nxt = taken ? ST  : WT;
                default: nxt = WNT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_array.sv
// rtl/btb_array.sv - BTB storage: async read port for IF, sync write/invalidate port for EX
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset (clears valid, ctr -> WNT)
//   rd_idx_i             IF lookup index
//   rd_valid_o/tag_o/target_o/ctr_o  entry contents at rd_idx_i (combinational)
//   upd_en_i             write the entry at upd_idx_i (resolved jb instruction)
//   upd_idx_i/tag_i/target_i         location and contents of the write
//   upd_jump_i           write is for JAL/JALR
//   upd_taken_i          resolved branch direction
//   inv_en_i             clear valid at inv_idx_i if its tag equals inv_tag_i
//   inv_idx_i/inv_tag_i  invalidate location and tag
module btb_array
    import cpu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_target_o,
    output ctr_t             rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic [TAG_W-1:0] upd_tag_i,
    input  logic [31:0]      upd_target_i,
    input  logic             upd_jump_i,
    input  logic             upd_taken_i,
    input  logic             inv_en_i,
    input  logic [IDX_W-1:0] inv_idx_i,
    input  logic [TAG_W-1:0] inv_tag_i
);

    logic             valid_q  [ENTRIES];
    ctr_t             ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    logic upd_hit;
    logic inv_hit;

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];

    // an alias (different tag) is treated as a replacement, not a counter step
    assign upd_hit = valid_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag_i);
    assign inv_hit = valid_q[inv_idx_i] && (tag_q[inv_idx_i] == inv_tag_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (upd_en_i) begin
            valid_q[upd_idx_i] <= 1'b1;
            ctr_q[upd_idx_i]   <= ctr_next(upd_hit, upd_jump_i, upd_taken_i, ctr_q[upd_idx_i]);
        end else if (inv_en_i && inv_hit) begin
            valid_q[inv_idx_i] <= 1'b0;
        end
    end

    // tag and target carry no reset; valid guards them
    always_ff @(posedge clk_i) begin
        if (!rst_i && upd_en_i) begin
            tag_q[upd_idx_i]    <= upd_tag_i;
            target_q[upd_idx_i] <= upd_target_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB next-PC predictor with EX-stage misprediction redirect
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   if_pc                fetch PC; pred_taken/pred_target are its prediction
//   ex_valid             EX holds a live instruction
//   ex_opcode, ex_pc     instr[6:2] and PC of the EX instruction
//   ex_taken, ex_target  resolved direction (forced taken for JAL/JALR) and target
//   ex_pred_taken/ex_pred_target  prediction piped from IF
//   redirect, redirect_pc, flush  misprediction recovery
//   mispredict_cnt       mispredictions since reset
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [4:0]  ex_opcode,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_target;
    ctr_t             rd_ctr;
    logic             if_hit;

    logic             ex_is_branch;
    logic             ex_is_jump;
    logic             ex_is_jb;
    logic             ex_taken_eff;
    logic [31:0]      actual_next;

    logic [31:0]      cnt_q;
    logic [31:0]      cnt_d;

    // the piped direction bit is implied by ex_pred_target and not needed here
    logic             unused_pred_taken;
    assign unused_pred_taken = ex_pred_taken;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // IF lookup
    assign if_hit      = rd_valid && (rd_tag == if_tag);
    assign pred_taken  = if_hit && rd_ctr[1];
    assign pred_target = pred_taken ? rd_target : (if_pc + 32'd4);

    // EX resolve
    assign ex_is_branch = (ex_opcode == OP_BRANCH);
    assign ex_is_jump   = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
    assign ex_is_jb     = ex_valid && (ex_is_branch || ex_is_jump);
    assign ex_taken_eff = ex_is_jump || ex_taken;
    assign actual_next  = ex_taken_eff ? ex_target : (ex_pc + 32'd4);

    // comparing full next-PCs also catches a non-jb instruction predicted taken
    assign redirect    = ex_valid && (ex_pred_target != actual_next);
    assign redirect_pc = redirect ? actual_next : 32'd0;
    assign flush       = redirect;

    assign cnt_d          = redirect ? (cnt_q + 32'd1) : cnt_q;
    assign mispredict_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    btb_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb_array (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_idx_i     (if_idx),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_target_o  (rd_target),
        .rd_ctr_o     (rd_ctr),
        .upd_en_i     (ex_is_jb),
        .upd_idx_i    (ex_idx),
        .upd_tag_i    (ex_tag),
        .upd_target_i (ex_target),
        .upd_jump_i   (ex_is_jump),
        .upd_taken_i  (ex_taken_eff),
        .inv_en_i     (ex_valid && !ex_is_jb && redirect),
        .inv_idx_i    (ex_idx),
        .inv_tag_i    (ex_tag)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard testbench for branch_predictor
module tb_branch_predictor;

    localparam logic [4:0] OP_BR  = 5'b11000;
    localparam logic [4:0] OP_JAL = 5'b11011;
    localparam logic [4:0] OP_JR  = 5'b11001;
    localparam logic [4:0] OP_ALU = 5'b01100;

    localparam int SEL_PTAKEN = 0;
    localparam int SEL_PTGT   = 1;
    localparam int SEL_REDIR  = 2;
    localparam int SEL_RPC    = 3;
    localparam int SEL_FLUSH  = 4;
    localparam int SEL_CNT    = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [4:0]  ex_opcode;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] mispredict_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_cnt  = 32'd0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .mispredict_cnt (mispredict_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_PTAKEN: observe = {31'd0, pred_taken};
            SEL_PTGT:   observe = pred_target;
            SEL_REDIR:  observe = {31'd0, redirect};
            SEL_RPC:    observe = redirect_pc;
            SEL_FLUSH:  observe = {31'd0, flush};
            default:    observe = mispredict_cnt;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // sample away from the active edge, drain the scoreboard, move to next cycle
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] op, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt);
        ex_valid       = v;
        ex_opcode      = op;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic idle(input string tag);
        set_ex(1'b0, OP_BR, 32'h0, 1'b1, 32'hdead_0000, 1'b0, 32'h0);
        push({tag, ".redirect"}, SEL_REDIR, 32'd0);
        push({tag, ".redirect_pc"}, SEL_RPC, 32'd0);
        push({tag, ".flush"}, SEL_FLUSH, 32'd0);
        push({tag, ".cnt"}, SEL_CNT, exp_cnt);
    endtask

    task automatic ex_op(input string tag, input logic [4:0] op, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt, input logic [31:0] ptgt,
                         input logic exp_redir, input logic [31:0] exp_rpc);
        set_ex(1'b1, op, pc, tk, tgt, (ptgt != pc + 32'd4), ptgt);
        push({tag, ".redirect"}, SEL_REDIR, {31'd0, exp_redir});
        push({tag, ".redirect_pc"}, SEL_RPC, exp_rpc);
        push({tag, ".flush"}, SEL_FLUSH, {31'd0, exp_redir});
        push({tag, ".cnt"}, SEL_CNT, exp_cnt);
        if (exp_redir) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_tk, input logic [31:0] exp_tgt);
        if_pc = pc;
        push({tag, ".pred_taken"}, SEL_PTAKEN, {31'd0, exp_tk});
        push({tag, ".pred_target"}, SEL_PTGT, exp_tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        if_pc = 32'h0;
        set_ex(1'b0, OP_ALU, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // empty BTB after reset
        idle("rst");
        lookup("rst", 32'h100, 1'b0, 32'h104);
        cycle();
        for (int i = 0; i < 16; i++) begin
            idle("rst_scan");
            lookup("rst_scan", 32'h2000 + 32'(i) * 32'd4, 1'b0, 32'h2004 + 32'(i) * 32'd4);
            cycle();
        end

        // non-jb traffic never redirects nor counts
        for (int i = 0; i < 10; i++) begin
            ex_op("alu", OP_ALU, 32'h400 + 32'(i) * 32'd4, 1'b0, 32'h0,
                  32'h404 + 32'(i) * 32'd4, 1'b0, 32'h0);
            cycle();
        end
        idle("alu_done");
        cycle();

        // taken branch, first sight; same-cycle lookup sees no bypass
        ex_op("br_t0", OP_BR, 32'h100, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80);
        lookup("br_t0_same", 32'h100, 1'b0, 32'h104);
        cycle();
        idle("br_t0_after");
        lookup("br_t0_after", 32'h100, 1'b1, 32'h80);
        cycle();

        // not taken three times: WT -> WNT -> SNT -> SNT
        ex_op("br_nt1", OP_BR, 32'h100, 1'b0, 32'h80, 32'h80, 1'b1, 32'h104);
        cycle();
        idle("br_nt1_after");
        lookup("br_nt1_after", 32'h100, 1'b0, 32'h104);
        cycle();
        ex_op("br_nt2", OP_BR, 32'h100, 1'b0, 32'h80, 32'h104, 1'b0, 32'h0);
        cycle();
        idle("br_nt2_after");
        lookup("br_nt2_after", 32'h100, 1'b0, 32'h104);
        cycle();
        ex_op("br_nt3", OP_BR, 32'h100, 1'b0, 32'h80, 32'h104, 1'b0, 32'h0);
        cycle();
        idle("br_nt3_after");
        lookup("br_nt3_after", 32'h100, 1'b0, 32'h104);
        cycle();

        // two taken steps from SNT: SNT -> WNT (still not taken) -> WT
        ex_op("br_up1", OP_BR, 32'h100, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80);
        cycle();
        idle("br_up1_after");
        lookup("br_up1_after", 32'h100, 1'b0, 32'h104);
        cycle();
        ex_op("br_up2", OP_BR, 32'h100, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80);
        cycle();
        idle("br_up2_after");
        lookup("br_up2_after", 32'h100, 1'b1, 32'h80);
        cycle();

        // JAL aliasing index 0 replaces the branch entry; ex_taken ignored
        ex_op("jal", OP_JAL, 32'h140, 1'b0, 32'h300, 32'h144, 1'b1, 32'h300);
        cycle();
        idle("jal_old");
        lookup("jal_old", 32'h100, 1'b0, 32'h104);
        cycle();
        idle("jal_new");
        lookup("jal_new", 32'h140, 1'b1, 32'h300);
        cycle();

        // JALR correct (ex_taken low still means taken), then wrong target
        ex_op("jalr_ok", OP_JR, 32'h1c8, 1'b0, 32'h200, 32'h200, 1'b0, 32'h0);
        cycle();
        ex_op("jalr_bad", OP_JR, 32'h1c8, 1'b1, 32'h200, 32'h204, 1'b1, 32'h200);
        cycle();
        idle("jalr_after");
        lookup("jalr_after", 32'h1c8, 1'b1, 32'h200);
        cycle();

        // non-jb predicted taken: redirect to fallthrough, entry invalidated
        ex_op("inv", OP_ALU, 32'h1c8, 1'b0, 32'h0, 32'h200, 1'b1, 32'h1cc);
        cycle();
        idle("inv_after");
        lookup("inv_after", 32'h1c8, 1'b0, 32'h1cc);
        cycle();
        idle("inv_other");
        lookup("inv_other", 32'h140, 1'b1, 32'h300);
        cycle();

        // same-cycle lookup and update returns the old target
        ex_op("same", OP_JAL, 32'h140, 1'b1, 32'h340, 32'h300, 1'b1, 32'h340);
        lookup("same_old", 32'h140, 1'b1, 32'h300);
        cycle();
        idle("same_new");
        lookup("same_new", 32'h140, 1'b1, 32'h340);
        cycle();

        // reset wins over a concurrent update
        rst = 1'b1;
        set_ex(1'b1, OP_JAL, 32'h100, 1'b1, 32'h500, 1'b0, 32'h104);
        if_pc = 32'h100;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = 32'd0;
        idle("rst_upd");
        lookup("rst_upd", 32'h100, 1'b0, 32'h104);
        cycle();
        idle("rst_upd2");
        lookup("rst_upd2", 32'h140, 1'b0, 32'h144);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch target buffer (BTB) with 2-bit saturating direction counters. In IF it predicts the next PC for the fetch address. In EX it receives the resolved outcome and the target from the jump/branch target unit, detects mispredictions, and drives the PC redirect and pipeline flush. It sits between the PC register, the IF/ID pipeline register, and the EX-stage jump/branch logic.

## Interface
- `ENTRIES`, 16: number of BTB entries; power of two, at least 2.
- `IDX_W`, $clog2(ENTRIES): index width; derived, not overridden.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `if_pc` in 32: current fetch PC.
- `pred_taken` out 1: prediction for `if_pc`; 1 = taken.
- `pred_target` out 32: predicted next PC.
- `ex_valid` in 1: EX stage holds a live, non-flushed instruction.
- `ex_opcode` in 5: instr[6:2] of the EX instruction.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_taken` in 1: resolved direction; ignored and treated as 1 for JAL/JALR.
- `ex_target` in 32: resolved target from the jump/branch target unit.
- `ex_pred_taken` in 1: prediction made for this instruction, piped from IF.
- `ex_pred_target` in 32: predicted next PC, piped from IF.
- `redirect` out 1: misprediction; PC must load `redirect_pc`.
- `redirect_pc` out 32: correct next PC.
- `flush` out 1: squash IF/ID and ID/EX; equals `redirect`.
- `mispredict_cnt` out 32: count of mispredictions since reset.

## Operation
- Control-transfer opcodes:
  - BRANCH = 5'b11000
  - JAL = 5'b11011
  - JALR = 5'b11001
  - `ex_is_jb` = `ex_valid` and opcode is one of these three.
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] is ignored.
- Entry fields: valid (1), tag, target (32), ctr (2).
- Lookup (combinational, IF):
  - hit = valid[idx] and tag[idx] == if_pc tag.
  - `pred_taken` = hit & ctr[1].
  - `pred_target` = `pred_taken` ? target[idx] : `if_pc` + 4, with 32-bit wrap.
- Resolve (combinational, EX):
  - actual_next = taken ? `ex_target` : `ex_pc` + 4.
  - `redirect` = `ex_valid` & (`ex_pred_target` != actual_next). This also catches a non-jb instruction that was wrongly predicted taken.
  - `redirect_pc` = actual_next when `redirect` is 1; otherwise 0.
- Update (sequential, on `ex_is_jb`):
  - The entry at `ex_pc` index is written with valid=1, tag, and target=`ex_target`.
  - Counter, entry hit (same tag and valid): JAL/JALR set ctr to 2'b11. BRANCH increments if taken, else decrements, saturating at 2'b00 and 2'b11.
  - Counter, entry miss or alias (replace): JAL/JALR set ctr to 2'b11. BRANCH sets 2'b10 if taken, else 2'b01.
  - A not-taken branch still updates the target field.
- Invalidate (sequential): if `ex_valid` and not `ex_is_jb` and `redirect`, clear valid at the `ex_pc` index when its tag matches.
- `mispredict_cnt` increments by 1 each cycle `redirect` is 1 and wraps at 2^32.

## Timing
- Lookup and resolve have zero latency (combinational). BTB writes become visible the cycle after the update edge.
- Same-cycle lookup and update to one index: the lookup returns the pre-update contents; there is no bypass.
- Reset:
  - all valid = 0, all ctr = 2'b01, `mispredict_cnt` = 0.
  - Tag and target arrays are not reset.
  - `redirect`, `flush`, `redirect_pc` are 0 while `ex_valid` = 0.
- Reset asserted mid-operation: takes priority over a concurrent update. The next cycle sees an empty BTB.
- `ex_valid` = 0: no update, no counter increment, `redirect` = 0.
- Stalls: the upstream stage holds `ex_*` stable and deasserts `ex_valid` on repeated cycles, so no double update occurs.

## Structure
- Shared `cpu_pkg` holds the opcode constants OP_BRANCH, OP_JAL, OP_JALR and the counter encodings SNT=00, WNT=01, WT=10, ST=11.
- One sub-module, `btb_array`: register-file storage with one asynchronous read port (IF) and one synchronous write port (EX). Valid and ctr are reset; tag and target are not.
- The counter update function lives in `cpu_pkg`.

## Test plan
- After reset, `if_pc`=0x100 gives `pred_taken`=0 and `pred_target`=0x104. Run 10 cycles with no jb instructions; `mispredict_cnt` stays 0.
- Taken BRANCH at `ex_pc`=0x100, `ex_target`=0x80, `ex_pred_target`=0x104:
  - `redirect`=1, `redirect_pc`=0x80, `mispredict_cnt`=1.
  - Next cycle, `if_pc`=0x100 gives `pred_taken`=1, `pred_target`=0x80 (ctr=10).
- Same branch resolved not taken three times: ctr goes 10→01→00→00. Prediction falls to not taken after the first update, and the count saturates with no wrap.
- JAL at 0x140 (index 0, same index as 0x100, tag 5):
  - replaces the 0x100 entry with ctr=11.
  - Lookup of 0x100 then misses (pred 0x104); lookup of 0x140 predicts its target.
- JALR correctly predicted (`ex_pred_target` == `ex_target`=0x200, taken) gives `redirect`=0. The same JALR with `ex_pred_target`=0x204 gives `redirect`=1, `redirect_pc`=0x200.
- Update and `rst` asserted in the same cycle: next cycle every lookup misses and `mispredict_cnt`=0. A same-cycle lookup and update at 0x100 returns the old entry.
